// File: rtl/wb_slave_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one classic-cycle slave among NR_MASTERS masters.
// The grant is held for a whole cyc burst; a watchdog ends hung accesses with err.
module wb_slave_rr_arbiter #(
    parameter int NR_MASTERS = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NR_MASTERS-1:0]    m_cyc_i,
    input  logic [NR_MASTERS-1:0]    m_stb_i,
    input  logic [NR_MASTERS-1:0]    m_we_i,
    input  logic [NR_MASTERS*AW-1:0] m_adr_i,
    input  logic [NR_MASTERS*DW-1:0] m_dat_i,
    input  logic [NR_MASTERS*DW/8-1:0] m_sel_i,
    output logic [NR_MASTERS-1:0]    m_ack_o,
    output logic [NR_MASTERS-1:0]    m_err_o,
    output logic [NR_MASTERS-1:0]    m_rty_o,
    output logic [DW-1:0]            m_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_rty_i,
    input  logic [DW-1:0]            s_dat_i,
    output logic [NR_MASTERS-1:0]    grant_o
);

    localparam int IW  = $clog2(NR_MASTERS);
    localparam int SW  = DW / 8;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                state_q;
    logic [NR_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]         gidx_q, pick_idx;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [WDW-1:0]        wd_cnt_q, wd_cnt_d;
    logic                  pick_vld;
    logic                  busy, sel_cyc, sel_stb, slv_resp, wd_hit;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NR_MASTERS) s = s - NR_MASTERS;
        return IW'(s);
    endfunction

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        for (int i = NR_MASTERS - 1; i >= 0; i--) begin
            if (m_cyc_i[wrap_add(rr_ptr_q, i)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_ptr_q, i);
            end
        end
    end

    assign grant_d  = NR_MASTERS'(1) << pick_idx;
    assign rr_ptr_d = wrap_add(gidx_q, 1);

    assign busy     = (state_q == BUSY);
    assign sel_cyc  = m_cyc_i[gidx_q];
    assign sel_stb  = m_stb_i[gidx_q];
    assign slv_resp = s_ack_i | s_err_i | s_rty_i;
    assign wd_hit   = (TIMEOUT > 0) && busy && (wd_cnt_q == WD_LIMIT);

    always_comb begin
        wd_cnt_d = '0;
        if (TIMEOUT > 0 && busy && sel_stb && !slv_resp && !wd_hit)
            wd_cnt_d = (wd_cnt_q == '1) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end

    // The expiry cycle pulls cyc/stb off the slave so it abandons the hung access.
    assign s_cyc_o = busy & sel_cyc & ~wd_hit;
    assign s_stb_o = busy & sel_stb & ~wd_hit;
    assign s_we_o  = busy & m_we_i[gidx_q];
    assign s_adr_o = busy ? m_adr_i[AW*int'(gidx_q) +: AW] : '0;
    assign s_dat_o = busy ? m_dat_i[DW*int'(gidx_q) +: DW] : '0;
    assign s_sel_o = busy ? m_sel_i[SW*int'(gidx_q) +: SW] : '0;

    assign m_ack_o = grant_q & {NR_MASTERS{s_ack_i}};
    assign m_err_o = grant_q & {NR_MASTERS{s_err_i | (wd_hit & ~slv_resp)}};
    assign m_rty_o = grant_q & {NR_MASTERS{s_rty_i}};
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update based on pre-edge values.
            wd_cnt_q <= wd_cnt_d;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_q <= BUSY;
                        grant_q <= grant_d;
                        gidx_q  <= pick_idx;
                    end
                end
                BUSY: begin
                    if (!sel_cyc) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_slave_rr_arbiter.sv
// Directed bench for wb_slave_rr_arbiter: per-master expected-response queues are
// filled by the master tasks and drained by a negedge monitor.
module tb_wb_slave_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] K_ACK = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] dat;
        bit          chk_dat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     m_cyc_i, m_stb_i, m_we_i;
    logic [N*AW-1:0]  m_adr_i;
    logic [N*DW-1:0]  m_dat_i;
    logic [N*DW/8-1:0] m_sel_i;
    logic [N-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0]    s_adr_o;
    logic [DW/8-1:0]  s_sel_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic             s_ack_i, s_err_i, s_rty_i;

    int   tests = 0;
    int   fails = 0;
    int   slave_mode = 0;   // 0 silent, 1 ack, 2 err
    int   slave_lat  = 2;
    logic [N-1:0] resp_seen = '0;
    exp_t q0[$];
    exp_t q1[$];

    wb_slave_rr_arbiter #(.NR_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Slave model: responds once stb has been visible for slave_lat cycles.
    initial begin
        int scnt;
        scnt = 0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        forever begin
            @(posedge clk); #2;
            s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
            if (rst) scnt = 0;
            else if (slave_mode != 0 && scnt == slave_lat) begin
                if (slave_mode == 1) s_ack_i = 1'b1;
                else s_err_i = 1'b1;
                scnt = 0;
            end
            else if (s_cyc_o && s_stb_o) scnt++;
            else scnt = 0;
        end
    end

    task automatic sb_check(input int m);
        exp_t e;
        logic [1:0] got_kind;
        int sz;
        sz = (m == 0) ? q0.size() : q1.size();
        got_kind = m_ack_o[m] ? K_ACK : (m_err_o[m] ? K_ERR : 2'd2);
        if (sz == 0) begin
            check($sformatf("unexpected_resp_m%0d", m), 32'(got_kind), 32'hFF);
            return;
        end
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("resp_kind_m%0d", m), 32'(got_kind), 32'(e.kind));
        if (e.chk_dat) check($sformatf("rdata_m%0d", m), m_dat_o, e.dat);
    endtask

    // Monitor: samples responses mid-cycle and scores them against the queues.
    initial begin
        logic [N-1:0] r;
        forever begin
            @(negedge clk);
            r = m_ack_o | m_err_o | m_rty_o;
            resp_seen = rst ? '0 : r;
            if (!rst && r != '0) begin
                check("single_resp", 32'($onehot(r)), 32'd1);
                for (int m = 0; m < N; m++)
                    if (r[m]) sb_check(m);
            end
        end
    end

    task automatic master_xfer(input int m, input bit we, input logic [31:0] adr,
                               input logic [31:0] dat, input int beats,
                               input logic [1:0] kind, input logic [31:0] rdat);
        exp_t e;
        int t;
        logic [31:0] a;
        a = adr;
        @(posedge clk); #1;
        m_cyc_i[m] = 1'b1; m_stb_i[m] = 1'b1; m_we_i[m] = we;
        m_sel_i[m*4 +: 4] = 4'hF;
        for (int b = 0; b < beats; b++) begin
            m_adr_i[m*AW +: AW] = a;
            m_dat_i[m*DW +: DW] = dat + 32'(b);
            e.kind = kind; e.dat = rdat; e.chk_dat = !we;
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            t = 0;
            do begin
                @(posedge clk); #1;
                t++;
            end while (!resp_seen[m] && t < 200);
            if (t >= 200) check($sformatf("resp_timeout_m%0d", m), 32'(t), 32'd0);
            a = a + 32'd4;
        end
        m_cyc_i[m] = 1'b0; m_stb_i[m] = 1'b0; m_we_i[m] = 1'b0;
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string name);
        int t;
        t = 0;
        while (grant_o !== g && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(grant_o), 32'(g));
    endtask

    task automatic wait_stb_then(input int n);
        int t;
        t = 0;
        @(negedge clk);
        while (!s_stb_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("stb_reached_slave", 32'(s_stb_o), 32'd1);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = 32'h1234_5678;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_s_stb", 32'(s_stb_o), 32'd0);
        check("rst_m_ack", 32'(m_ack_o), 32'd0);
        rst = 1'b0;

        // Single write from m0, slave ack after latency 2
        slave_mode = 1; slave_lat = 2;
        fork
            master_xfer(0, 1'b1, 32'h10, 32'hA5, 1, K_ACK, 32'h0);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                check("t1_idle_no_cyc", 32'(s_cyc_o), 32'd0);
                @(negedge clk);
                check("t1_s_adr", s_adr_o, 32'h10);
                check("t1_s_dat", s_dat_o, 32'hA5);
                check("t1_s_we", 32'(s_we_o), 32'd1);
                check("t1_grant", 32'(grant_o), 32'd1);
            end
        join

        // Read from m0, data broadcast from slave
        s_dat_i = 32'hCAFE_0042;
        master_xfer(0, 1'b0, 32'h20, 32'h0, 1, K_ACK, 32'hCAFE_0042);

        // Tie from reset: m0, then m1; next tie wraps back to m0
        do_reset();
        fork
            master_xfer(0, 1'b1, 32'h100, 32'h1, 1, K_ACK, 32'h0);
            master_xfer(1, 1'b1, 32'h200, 32'h2, 1, K_ACK, 32'h0);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                wait_grant(2'b01, "t2_first_m0");
                wait_grant(2'b10, "t2_then_m1");
            end
        join
        fork
            master_xfer(0, 1'b1, 32'h104, 32'h3, 1, K_ACK, 32'h0);
            master_xfer(1, 1'b1, 32'h204, 32'h4, 1, K_ACK, 32'h0);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                wait_grant(2'b01, "t2_wrap_m0");
                wait_grant(2'b10, "t2_wrap_then_m1");
            end
        join

        // m1 4-beat burst while m0 waits
        fork
            master_xfer(1, 1'b1, 32'h300, 32'h10, 4, K_ACK, 32'h0);
            begin
                repeat (2) @(posedge clk);
                master_xfer(0, 1'b1, 32'h400, 32'h20, 1, K_ACK, 32'h0);
            end
            begin
                int nack;
                int t;
                nack = 0; t = 0;
                @(posedge clk); #1;
                @(negedge clk);
                wait_grant(2'b10, "t3_grant_m1");
                while (m_cyc_i[1] && t < 200) begin
                    if (m_ack_o[1]) begin
                        nack++;
                        check("t3_burst_grant", 32'(grant_o), 32'd2);
                        check("t3_m0_no_ack", 32'(m_ack_o[0]), 32'd0);
                    end
                    @(negedge clk);
                    t++;
                end
                check("t3_beats", 32'(nack), 32'd4);
            end
        join

        // Watchdog: silent slave, err 8 cycles after stb reaches the slave
        slave_mode = 0;
        fork
            master_xfer(0, 1'b1, 32'h500, 32'h5, 1, K_ERR, 32'h0);
            begin
                @(posedge clk); #1;
                wait_stb_then(8);
                check("t4_no_err_early", 32'(m_err_o), 32'd0);
                @(negedge clk);
                check("t4_err", 32'(m_err_o), 32'd1);
                check("t4_stb_forced", 32'(s_stb_o), 32'd0);
                check("t4_cyc_forced", 32'(s_cyc_o), 32'd0);
            end
        join

        // Slave ack coinciding with watchdog expiry: ack wins
        slave_mode = 1; slave_lat = 8;
        fork
            master_xfer(0, 1'b1, 32'h600, 32'h6, 1, K_ACK, 32'h0);
            begin
                @(posedge clk); #1;
                wait_stb_then(9);
                check("t5_ack_wins", 32'(m_ack_o), 32'd1);
                check("t5_no_err", 32'(m_err_o), 32'd0);
            end
        join

        // Slave err routed to granted m1 only
        slave_mode = 2; slave_lat = 1;
        master_xfer(1, 1'b1, 32'h700, 32'h7, 1, K_ERR, 32'h0);

        // Async reset between edges while BUSY
        slave_mode = 0;
        @(posedge clk); #1;
        m_cyc_i[0] = 1'b1; m_stb_i[0] = 1'b1; m_adr_i[31:0] = 32'h800;
        @(negedge clk);
        @(negedge clk);
        check("t7_busy_cyc", 32'(s_cyc_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t7_rst_s_cyc", 32'(s_cyc_o), 32'd0);
        check("t7_rst_s_stb", 32'(s_stb_o), 32'd0);
        check("t7_rst_grant", 32'(grant_o), 32'd0);
        check("t7_rst_m_ack", 32'(m_ack_o), 32'd0);
        m_cyc_i = '0; m_stb_i = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
